// File: rtl/note_regs_axil.sv
// AXI4-Lite slave exposing four 32-bit registers; REG0/REG1 drive note_on,
// note_num and velocity, and each committed write to REG1 pulses note_strobe.
module note_regs_axil #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            note_on,
    output logic [6:0]                      note_num,
    output logic [6:0]                      velocity,
    output logic                            note_strobe
);
    localparam int NUM_REGS  = 4;
    localparam int NUM_LANES = C_S_AXI_DATA_WIDTH / 8;

    logic                                     aw_held_reg;
    logic                                     w_held_reg;
    logic                                     bvalid_reg;
    logic                                     rvalid_reg;
    logic                                     note_strobe_reg;
    logic [1:0]                               aw_idx_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0]            w_data_reg;
    logic [NUM_LANES-1:0]                     w_strb_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0]            rdata_reg;
    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;

    logic                          aw_fire;
    logic                          w_fire;
    logic                          ar_fire;
    logic                          commit;
    logic [1:0]                    wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [NUM_LANES-1:0]          wr_strb;
    logic                          unused_ok;

    assign S_AXI_AWREADY = !ARESET && !aw_held_reg && !bvalid_reg;
    assign S_AXI_WREADY  = !ARESET && !w_held_reg && !bvalid_reg;
    assign S_AXI_ARREADY = !ARESET && !rvalid_reg;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;

    // The write commits in the cycle the later of AW/W arrives, taking that
    // half straight from the bus and the other half from its holding register.
    assign commit  = (aw_fire || aw_held_reg) && (w_fire || w_held_reg) && !bvalid_reg;
    assign wr_idx  = aw_fire ? S_AXI_AWADDR[3:2] : aw_idx_reg;
    assign wr_data = w_fire ? S_AXI_WDATA : w_data_reg;
    assign wr_strb = w_fire ? S_AXI_WSTRB : w_strb_reg;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_reg     <= 1'b0;
            w_held_reg      <= 1'b0;
            bvalid_reg      <= 1'b0;
            aw_idx_reg      <= '0;
            w_data_reg      <= '0;
            w_strb_reg      <= '0;
            note_strobe_reg <= 1'b0;
        end else begin
            if (bvalid_reg && S_AXI_BREADY) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held_reg <= 1'b1;
                    aw_idx_reg  <= S_AXI_AWADDR[3:2];
                end
                if (w_fire) begin
                    w_held_reg <= 1'b1;
                    w_data_reg <= S_AXI_WDATA;
                    w_strb_reg <= S_AXI_WSTRB;
                end
                if (commit) begin
                    bvalid_reg <= 1'b1;
                end
            end
            note_strobe_reg <= commit && (wr_idx == 2'd1);
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [C_S_AXI_DATA_WIDTH-1:0] data_reg;

        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                data_reg <= '0;
            end else if (commit && (wr_idx == 2'(gi))) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (wr_strb[k]) begin
                        data_reg[8*k +: 8] <= wr_data[8*k +: 8];
                    end
                end
            end
        end

        assign regs[gi] = data_reg;
    end

    // Read data is captured at the AR handshake, so a same-cycle write to the
    // addressed register is not yet visible and the old value is returned.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (ar_fire) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= regs[S_AXI_ARADDR[3:2]];
        end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

    assign S_AXI_BVALID = bvalid_reg;
    assign S_AXI_BRESP  = 2'b00;
    assign S_AXI_RVALID = rvalid_reg;
    assign S_AXI_RDATA  = rdata_reg;
    assign S_AXI_RRESP  = 2'b00;

    assign note_on     = regs[0][0];
    assign note_num    = regs[1][6:0];
    assign velocity    = regs[1][14:8];
    assign note_strobe = note_strobe_reg;

    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_note_regs_axil.sv
// Directed bench for note_regs_axil: a register model predicts read data,
// expected values are queued at AR issue and compared when R arrives.
module tb_note_regs_axil;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        note_on;
    logic [6:0]  note_num;
    logic [6:0]  velocity;
    logic        note_strobe;

    always #5 ACLK = ~ACLK;

    note_regs_axil dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .note_on(note_on), .note_num(note_num), .velocity(velocity),
        .note_strobe(note_strobe)
    );

    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          strobe_edges = 0;
    logic [31:0] model [4];
    logic [31:0] exp_q [$];

    always @(posedge ACLK) begin
        if (note_strobe === 1'b1) strobe_edges++;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) model[addr[3:2]][8*k +: 8] = data[8*k +: 8];
        end
    endtask

    // Present AW and W together and return once both are accepted; B is left pending.
    task automatic start_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        bit aw_ok = 0;
        bit w_ok = 0;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        while (!(aw_ok && w_ok) && n < 20) begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_ok = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_ok = 1;
            tick();
            n++;
            if (aw_ok) S_AXI_AWVALID = 1'b0;
            if (w_ok) S_AXI_WVALID = 1'b0;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("write_accept", 32'(aw_ok && w_ok), 32'd1);
        model_write(addr, data, strb);
    endtask

    task automatic finish_b();
        int n = 0;
        while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
        check("bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("bresp", 32'(S_AXI_BRESP), 32'd0);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        start_write(addr, data, strb);
        finish_b();
    endtask

    task automatic issue_read(input logic [3:0] addr);
        int n = 0;
        exp_q.push_back(model[addr[3:2]]);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
        check("ar_accept", 32'(S_AXI_ARREADY), 32'd1);
        tick();
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic take_read(input string tag);
        int n = 0;
        logic [31:0] exp;
        while (!S_AXI_RVALID && n < 20) begin tick(); n++; end
        check("rvalid", 32'(S_AXI_RVALID), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check(tag, S_AXI_RDATA, exp);
        check("rresp", 32'(S_AXI_RRESP), 32'd0);
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, input string tag);
        issue_read(addr);
        take_read(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        repeat (3) tick();

        // Reset state
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        check("rst_notes", 32'({note_on, note_num, velocity, note_strobe}), 32'd0);
        ARESET = 1'b0;
        tick();
        check("post_rst_readies", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'b111);

        // Basic write/read of all four registers
        for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) axi_read(4'(4 * i), "rd_basic");

        // Byte lanes
        axi_write(4'h8, 32'hAABBCCDD, 4'hF);
        axi_write(4'h8, 32'h11223344, 4'b0101);
        axi_read(4'h8, "rd_bytelane");
        check("bytelane_const", model[2], 32'hAA22CC44);
        axi_write(4'h9, 32'hFFFFFFFF, 4'b0000);
        axi_read(4'h8, "rd_strb_zero");

        // W leads AW by three cycles
        S_AXI_WDATA = 32'h0000_5A5A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        check("w_first_wready_low", 32'(S_AXI_WREADY), 32'd0);
        check("w_first_awready", 32'(S_AXI_AWREADY), 32'd1);
        tick();
        tick();
        check("w_first_no_b", 32'(S_AXI_BVALID), 32'd0);
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        model_write(4'h0, 32'h0000_5A5A, 4'hF);
        check("w_first_bvalid", 32'(S_AXI_BVALID), 32'd1);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("w_first_b_done", 32'(S_AXI_BVALID), 32'd0);
        tick();
        tick();
        check("w_first_single_b", 32'(S_AXI_BVALID), 32'd0);
        check("w_first_readies", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'b11);
        axi_read(4'h0, "rd_w_first");

        // B back-pressure
        start_write(4'h8, 32'h0000_0055, 4'hF);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 32'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 32'b100);
            tick();
        end
        finish_b();

        // R back-pressure
        issue_read(4'h8);
        for (int i = 0; i < 4; i++) begin
            check("rbp_rvalid", 32'(S_AXI_RVALID), 32'd1);
            check("rbp_rdata", S_AXI_RDATA, model[2]);
            tick();
        end
        take_read("rd_rbp");

        // Note registers and strobe
        s0 = strobe_edges;
        start_write(4'h4, 32'h0000_4A3C, 4'hF);
        check("note_num", 32'(note_num), 32'h3C);
        check("velocity", 32'(velocity), 32'h4A);
        finish_b();
        tick();
        tick();
        check("strobe_once", 32'(strobe_edges - s0), 32'd1);
        s0 = strobe_edges;
        axi_write(4'h4, 32'hFFFF_FFFF, 4'b0000);
        tick();
        check("strobe_nostrb", 32'(strobe_edges - s0), 32'd1);
        check("note_num_kept", 32'(note_num), 32'h3C);
        s0 = strobe_edges;
        axi_write(4'h8, 32'h0000_0001, 4'hF);
        tick();
        check("strobe_other_reg", 32'(strobe_edges - s0), 32'd0);
        axi_write(4'h0, 32'h0000_0001, 4'hF);
        check("note_on", 32'(note_on), 32'd1);

        // AR and write commit to the same register in one cycle
        exp_q.push_back(model[3]);
        S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hDEAD_0000; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        check("same_cycle_readies",
              32'({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY}), 32'b111);
        tick();
        S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        model_write(4'hC, 32'hDEAD_0000, 4'hF);
        take_read("rd_pre_write");
        finish_b();
        axi_read(4'hC, "rd_post_write");

        // Reset while a B response is pending
        start_write(4'h4, 32'h0000_1234, 4'hF);
        check("mid_bvalid", 32'(S_AXI_BVALID), 32'd1);
        ARESET = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) model[i] = '0;
        check("mid_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("mid_rst_notes", 32'({note_on, note_num, velocity}), 32'd0);
        ARESET = 1'b0;
        tick();
        check("mid_rst_no_b", 32'(S_AXI_BVALID), 32'd0);
        check("mid_rst_readies",
              32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'b111);
        axi_read(4'h4, "rd_after_rst");

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end
endmodule
